// File: rtl/alu_seq_param.sv
// Sequential word-serial ALU: add/sub, shift-add multiply and restoring divide.
// Optional macro ALU_DIV_CHECK_EN adds the err port and early rejection of overflowing divisions.
module alu_seq_param #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BEGIN,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] inbus,
  output logic [WIDTH-1:0] outbus,
  output logic             out_valid,
  output logic             busy,
  output logic             END
`ifdef ALU_DIV_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {IDLE, LOAD_B, LOAD_C, EXEC, OUT_HI, OUT_LO} state_t;

  state_t           state, state_next;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa, opb, hi, lo;
  logic [CW-1:0]    cnt;
  logic             ovf;

  logic [WIDTH:0]   mul_sum, div_rem;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             div_ovf_c;

  // One iteration: {hi,lo} is the product accumulator or the remainder/quotient pair
  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opa} : '0);
    div_rem = {hi, lo[WIDTH-1]};
    div_ge  = (div_rem >= {1'b0, opb});
    if (op == OP_DIV) begin
      step_hi = div_ge ? WIDTH'(div_rem - {1'b0, opb}) : div_rem[WIDTH-1:0];
      step_lo = {lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  // Quotient cannot fit in WIDTH bits when dividend high word >= divisor (includes divide by zero)
  always_comb begin
    div_ovf_c = 1'b0;
`ifdef ALU_DIV_CHECK_EN
    div_ovf_c = (state == LOAD_C) && (hi >= inbus);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (BEGIN) state_next = LOAD_B;
      LOAD_B:  state_next = (op == OP_DIV) ? LOAD_C : EXEC;
      LOAD_C:  state_next = div_ovf_c ? OUT_HI : EXEC;
      EXEC: begin
        if (op == OP_ADD || op == OP_SUB) state_next = OUT_LO;
        else if (cnt == CW'(1))           state_next = OUT_HI;
      end
      OUT_HI:  state_next = OUT_LO;
      OUT_LO:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, iteration datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      op        <= '0;
      opa       <= '0;
      opb       <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      outbus    <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      END       <= 1'b0;
`ifdef ALU_DIV_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      outbus    <= '0;
      out_valid <= 1'b0;
      END       <= 1'b0;
`ifdef ALU_DIV_CHECK_EN
      err       <= 1'b0;
`endif
      busy      <= (state_next != IDLE);

      case (state)
        IDLE: begin
          if (BEGIN) begin
            op  <= op_code;
            opa <= inbus;
            ovf <= 1'b0;
          end
        end
        LOAD_B: begin
          opb <= inbus;
          lo  <= inbus;
          hi  <= (op == OP_DIV) ? opa : '0;
          if (op != OP_DIV) cnt <= CW'(WIDTH);
        end
        LOAD_C: begin
          opb <= inbus;
          ovf <= div_ovf_c;
          cnt <= CW'(WIDTH);
        end
        EXEC: begin
          hi  <= step_hi;
          lo  <= step_lo;
          cnt <= cnt - CW'(1);
        end
        default: ;
      endcase

      if (state_next == OUT_HI) begin
        out_valid <= 1'b1;
        if (div_ovf_c)          outbus <= '1;
        else if (op == OP_DIV)  outbus <= step_lo;
        else                    outbus <= step_hi;
      end

      if (state_next == OUT_LO) begin
        out_valid <= 1'b1;
        END       <= 1'b1;
        case (op)
          OP_ADD:  outbus <= opa + opb;
          OP_SUB:  outbus <= opa - opb;
          OP_DIV:  outbus <= ovf ? '1 : hi;
          default: outbus <= lo;
        endcase
`ifdef ALU_DIV_CHECK_EN
        err <= ovf;
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param: random and directed operations against an arithmetic model.
module tb_alu_seq_param;
  localparam int unsigned W    = 8;
  localparam int unsigned MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         BEGIN;
  logic [1:0]   op_code;
  logic [W-1:0] inbus;
  logic [W-1:0] outbus;
  logic         out_valid;
  logic         busy;
  logic         END;
`ifdef ALU_DIV_CHECK_EN
  logic         err;
`endif

  alu_seq_param #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .BEGIN     (BEGIN),
    .op_code   (op_code),
    .inbus     (inbus),
    .outbus    (outbus),
    .out_valid (out_valid),
    .busy      (busy),
    .END       (END)
`ifdef ALU_DIV_CHECK_EN
    ,
    .err       (err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int unsigned val;
    bit          last;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input int unsigned v, input bit l, input bit e);
    exp_t x;
    x.cyc = c; x.val = v & MASK; x.last = l; x.err = e;
    sb.push_back(x);
  endtask

  // Reference model: expected words and their cycles, relative to the BEGIN cycle k
  task automatic model(input int k, input int unsigned op, input int unsigned w0,
                       input int unsigned w1, input int unsigned w2);
    longint unsigned p, dv;
    case (op)
      0: push(k + 3, w0 + w1, 1'b1, 1'b0);
      1: push(k + 3, w0 - w1, 1'b1, 1'b0);
      2: begin
        p = longint'(w0) * longint'(w1);
        push(k + W + 2, int'(p >> W), 1'b0, 1'b0);
        push(k + W + 3, int'(p), 1'b1, 1'b0);
      end
      default: begin
`ifdef ALU_DIV_CHECK_EN
        if (w0 >= w2) begin
          push(k + 3, MASK, 1'b0, 1'b0);
          push(k + 4, MASK, 1'b1, 1'b1);
          return;
        end
`endif
        dv = (longint'(w0) << W) | longint'(w1);
        push(k + W + 3, int'(dv / longint'(w2)), 1'b0, 1'b0);
        push(k + W + 4, int'(dv % longint'(w2)), 1'b1, 1'b0);
      end
    endcase
  endtask

  // Output monitor: every valid word must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", longint'(outbus), -1);
      end else begin
        e = sb.pop_front();
        chk("outbus", longint'(outbus), longint'(e.val));
        chk("end_flag", longint'(END), longint'(e.last));
        chk("word_cycle", longint'(cyc), longint'(e.cyc));
`ifdef ALU_DIV_CHECK_EN
        chk("err", longint'(err), longint'(e.err));
`endif
      end
    end else begin
      chk("idle_outbus", longint'(outbus), 0);
      chk("idle_end", longint'(END), 0);
    end
  end

  // Called at a negedge with the DUT idle; BEGIN lands in this very cycle
  task automatic issue(input int unsigned op, input int unsigned w0,
                       input int unsigned w1, input int unsigned w2);
    BEGIN   = 1'b1;
    op_code = 2'(op);
    inbus   = W'(w0);
    model(cyc, op, w0, w1, w2);
    @(negedge clk);
    BEGIN   = 1'($urandom);
    op_code = 2'($urandom);
    inbus   = W'(w1);
    if (op == 3) begin
      @(negedge clk);
      BEGIN = 1'($urandom);
      inbus = W'(w2);
    end
  endtask

  // Wait for IDLE while toggling ignored BEGIN/op_code/inbus noise; returns at an idle negedge
  task automatic wait_idle();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (!busy) begin
        BEGIN = 1'b0;
        done  = 1'b1;
      end else begin
        BEGIN   = 1'($urandom);
        op_code = 2'($urandom);
        inbus   = W'($urandom);
      end
    end
    if (!done) chk("idle_timeout", 1, 0);
  endtask

  task automatic rand_op();
    int unsigned op, a, b, d, dh;
    op = $urandom_range(0, 3);
    a  = $urandom_range(0, MASK);
    b  = $urandom_range(0, MASK);
    if (op == 3) begin
      d  = $urandom_range(1, MASK);
      dh = $urandom_range(0, d - 1);
`ifdef ALU_DIV_CHECK_EN
      if ($urandom_range(0, 3) == 0) begin
        d  = $urandom_range(0, MASK);
        dh = $urandom_range(0, MASK);
      end
`endif
      issue(3, dh, a, d);
    end else begin
      issue(op, a, b, 0);
    end
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 200000", $time);
    $fatal(1);
  end

  initial begin
    int k;
    reset = 1'b1; BEGIN = 1'b0; op_code = '0; inbus = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_valid", longint'(out_valid), 0);
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors, each started the cycle after the previous END
    issue(0, 56, 89, 0);     wait_idle();
    issue(1, 56, 89, 0);     wait_idle();
    issue(2, 56, 89, 0);     wait_idle();
    issue(3, 8'h12, 8'h7B, 8'h59); wait_idle();
    issue(0, 255, 1, 0);     wait_idle();
    issue(1, 0, 1, 0);       wait_idle();
    issue(2, 255, 255, 0);   wait_idle();
    issue(3, 8'hFE, 8'hFF, 8'hFF); wait_idle();
`ifdef ALU_DIV_CHECK_EN
    issue(3, 8'h00, 8'h10, 8'h00); wait_idle();
    issue(3, 8'h40, 8'h00, 8'h40); wait_idle();
`endif

    // Reset mid-multiply aborts with no output, then an add runs normally
    BEGIN = 1'b1; op_code = 2'd2; inbus = W'(56);
    k = cyc;
    @(negedge clk);
    BEGIN = 1'b0; inbus = W'(89);
    while (cyc < k + 5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", longint'(busy), 0);
    chk("abort_valid", longint'(out_valid), 0);
    chk("abort_outbus", longint'(outbus), 0);
    chk("abort_sb_empty", longint'(sb.size()), 0);
    @(negedge clk);
    chk("abort_restart_cycle", longint'(cyc), longint'(k + 7));
    issue(0, 1, 2, 0);
    wait_idle();

    // Reset wins over a simultaneous BEGIN
    reset = 1'b1; BEGIN = 1'b1; op_code = 2'd0; inbus = W'(7);
    @(negedge clk);
    reset = 1'b0; BEGIN = 1'b0;
    chk("rst_vs_begin_busy", longint'(busy), 0);
    repeat (4) @(negedge clk);
    chk("rst_vs_begin_idle", longint'(busy), 0);

    for (int i = 0; i < 40; i++) rand_op();

    repeat (3) @(negedge clk);
    chk("sb_drained", longint'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
